regwb_arbiter: RTL and testbench
================================

# regwb_arbiter

Write-back arbiter and hazard scoreboard for the 16 x 8-bit register bank. Two requesters share the bank's single write port: the ALU result path and the memory load path. Requests arrive on valid/ready handshakes and are granted round-robin. Each winner drives one registered write (data, address, status flags) into the bank. An optional scoreboard tracks destination registers with outstanding writes so the decode stage can stall on read-after-write hazards.

## Interface
Parameters:
- AW, 4, register address width (16 registers)
- DW, 8, data width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock; all state changes on its rising edge
  - rst  in  1  synchronous, active-high reset
- ALU requester:
  - alu_valid  in  1  ALU write-back request
  - alu_ready  out  1  ALU request accepted this cycle (combinational)
  - alu_addr  in  AW  destination register
  - alu_data  in  DW  result
  - alu_flags  in  8  new status-register value
- Load requester:
  - ld_valid  in  1  load write-back request
  - ld_ready  out  1  load request accepted this cycle (combinational)
  - ld_addr  in  AW  destination register
  - ld_data  in  DW  loaded byte
- Bank side:
  - bank_stall  in  1  bank cannot take a write this cycle
  - wr_en  out  1  register-bank write enable
  - wr_addr  out  AW  register-bank write address
  - wr_data  out  DW  register-bank write data
  - sreg_we  out  1  status-register write strobe (ALU writes only)
  - sreg_data  out  8  status-register value
- Decode side:
  - iss_valid  in  1  decode issues an instruction that writes iss_addr
  - iss_addr  in  AW  destination of the issued instruction
  - src_a  in  AW  first source operand
  - src_b  in  AW  second source operand
  - hazard  out  1  src_a, src_b or iss_addr is busy (combinational)
  - busy  out  16  scoreboard bit per register

## Operation
- **Grant:**
  - When bank_stall=1, both readies are 0.
  - Otherwise, if only one valid is high, that requester gets ready=1.
  - If both are high, the one not granted last (last_grant flag) wins. last_grant resets to LOAD, so the ALU wins the first tie.
  - last_grant updates only on an accepted transfer (valid & ready).
  - At most one ready is high per cycle.
- **Transfer:** valid & ready at edge N latches addr/data into wr_addr/wr_data and sets wr_en=1 for cycle N+1.
  - An ALU transfer also latches alu_flags and sets sreg_we=1.
  - A load transfer sets sreg_we=0.
- **Idle:** with no transfer at edge N, wr_en and sreg_we are 0 in cycle N+1. wr_addr, wr_data and sreg_data hold their last values.
- **Requester rule:** once valid is asserted, the requester holds valid and its payload stable until ready. The arbiter does not check this; the bench does.
- **Scoreboard:**
  - iss_valid=1 with hazard=0 at an edge sets busy[iss_addr].
  - iss_valid=1 with hazard=1 is ignored; decode must re-present it.
  - busy[wr_addr] clears at the edge ending a wr_en=1 cycle.
  - If a set and a clear target the same register at the same edge, set wins.
  - hazard = busy[src_a] | busy[src_b] | (iss_valid & busy[iss_addr]).
- **Reset** (while rst=1, at the next edge): wr_en=0, sreg_we=0, wr_addr=0, wr_data=0, sreg_data=0, busy=0, last_grant=LOAD.
  - alu_ready and ld_ready are forced 0 while rst=1.
  - A write already latched into wr_en is dropped.

## Timing
- Latency: accepted at edge N, written by the bank at edge N+1. The busy bit clears at edge N+1 and is low from cycle N+2.
- Throughput: one write per cycle, sustained. Back-to-back ALU and load requests alternate.
- bank_stall is sampled combinationally. It blocks acceptance only; an already-latched wr_en still completes.
- Ready has a combinational path from valid and bank_stall. valid has no path from ready.
- hazard is combinational from busy and the decode inputs. busy itself is registered.

## Configuration
- REGWB_SCOREBOARD_EN defined: scoreboard as described.
- Not defined:
  - busy is tied to 0 and hazard to 0.
  - iss_valid, iss_addr, src_a and src_b are ignored.
  - No scoreboard flops are built.
  - Grant, write and reset behaviour is identical.

## Test plan
- Reset: rst=1 for 2 cycles with both valids high -> both readies 0, wr_en=0, busy=0. First cycle after reset grants ALU.
- Contention: both valid for 4 cycles (ALU r3=0x11, load r5=0x22) -> grants alternate ALU, LOAD, ALU, LOAD. wr_en=1 on 4 consecutive cycles. sreg_we=1 only on ALU writes.
- Stall: ld_valid=1 (r7=0x5A) with bank_stall=1 for 3 cycles -> ld_ready=0 for 3 cycles. Ready rises the cycle stall falls; wr_addr=7, wr_data=0x5A the cycle after.
- Scoreboard (macro defined):
  - Issue r4, then src_a=4 -> hazard=1.
  - Load writes r4 at edge N -> busy[4] clears at edge N+1, hazard=0 in cycle N+2.
- Simultaneous set/clear (macro defined): iss r2 at the same edge the r2 write completes -> busy[2] stays 1.
- Macro undefined: run the scoreboard scenario -> busy=0 and hazard=0 throughout. Bank writes are identical to the macro-defined run.

Source files
------------

// File: rtl/regwb_arbiter_if.sv
// Write-back bus between the ALU/load requesters, the register bank and decode.
// The arbiter connects through the slave modport; requesters/bank/decode use master.
interface regwb_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic              alu_valid;
  logic              alu_ready;
  logic [AW-1:0]     alu_addr;
  logic [DW-1:0]     alu_data;
  logic [7:0]        alu_flags;

  logic              ld_valid;
  logic              ld_ready;
  logic [AW-1:0]     ld_addr;
  logic [DW-1:0]     ld_data;

  logic              bank_stall;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              sreg_we;
  logic [7:0]        sreg_data;

  logic              iss_valid;
  logic [AW-1:0]     iss_addr;
  logic [AW-1:0]     src_a;
  logic [AW-1:0]     src_b;
  logic              hazard;
  logic [(1<<AW)-1:0] busy;

  modport slave (
    input  alu_valid, alu_addr, alu_data, alu_flags,
    input  ld_valid, ld_addr, ld_data,
    input  bank_stall,
    input  iss_valid, iss_addr, src_a, src_b,
    output alu_ready, ld_ready,
    output wr_en, wr_addr, wr_data, sreg_we, sreg_data,
    output hazard, busy
  );

  modport master (
    output alu_valid, alu_addr, alu_data, alu_flags,
    output ld_valid, ld_addr, ld_data,
    output bank_stall,
    output iss_valid, iss_addr, src_a, src_b,
    input  alu_ready, ld_ready,
    input  wr_en, wr_addr, wr_data, sreg_we, sreg_data,
    input  hazard, busy
  );
endinterface

// File: rtl/regwb_arbiter.sv
// Round-robin write-back arbiter for the register bank with optional RAW scoreboard.
// Define REGWB_SCOREBOARD_EN to build the busy/hazard scoreboard; otherwise busy=0, hazard=0.
module regwb_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  regwb_arbiter_if.slave  bus
);

  localparam int NREG = 1 << AW;

  typedef enum logic {
    GRANT_ALU  = 1'b0,
    GRANT_LOAD = 1'b1
  } grant_e;

  grant_e          last_grant_q, last_grant_d;
  logic            alu_fire, ld_fire;

  logic            wr_en_q, wr_en_d;
  logic            sreg_we_q, sreg_we_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [7:0]      sreg_data_q, sreg_data_d;

  // Grant state register
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= GRANT_LOAD;
    else     last_grant_q <= last_grant_d;
  end

  // Grant next-state: moves only on an accepted transfer
  always_comb begin
    last_grant_d = last_grant_q;
    if (alu_fire)     last_grant_d = GRANT_ALU;
    else if (ld_fire) last_grant_d = GRANT_LOAD;
  end

  // Grant outputs: the requester not served last wins a tie
  always_comb begin
    bus.alu_ready = 1'b0;
    bus.ld_ready  = 1'b0;
    if (!rst && !bus.bank_stall) begin
      if (bus.alu_valid && (!bus.ld_valid || last_grant_q == GRANT_LOAD))
        bus.alu_ready = 1'b1;
      else if (bus.ld_valid)
        bus.ld_ready = 1'b1;
    end
    alu_fire = bus.alu_valid & bus.alu_ready;
    ld_fire  = bus.ld_valid  & bus.ld_ready;
  end

  always_comb begin
    wr_en_d     = alu_fire | ld_fire;
    sreg_we_d   = alu_fire;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    sreg_data_d = sreg_data_q;
    if (alu_fire) begin
      wr_addr_d   = bus.alu_addr;
      wr_data_d   = bus.alu_data;
      sreg_data_d = bus.alu_flags;
    end else if (ld_fire) begin
      wr_addr_d   = bus.ld_addr;
      wr_data_d   = bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q     <= 1'b0;
      sreg_we_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      sreg_data_q <= '0;
    end else begin
      wr_en_q     <= wr_en_d;
      sreg_we_q   <= sreg_we_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      sreg_data_q <= sreg_data_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.sreg_we   = sreg_we_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.sreg_data = sreg_data_q;

`ifdef REGWB_SCOREBOARD_EN
  logic [NREG-1:0] busy_q, busy_d;
  logic            hazard;

  // Set is applied after clear so a same-edge issue to the retiring register wins
  always_comb begin
    hazard = busy_q[bus.src_a] | busy_q[bus.src_b] |
             (bus.iss_valid & busy_q[bus.iss_addr]);
    busy_d = busy_q;
    if (wr_en_q)                    busy_d[wr_addr_q]    = 1'b0;
    if (bus.iss_valid && !hazard)   busy_d[bus.iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign bus.busy   = busy_q;
  assign bus.hazard = hazard;
`else
  logic unused_decode;
  assign unused_decode = ^{bus.iss_valid, bus.iss_addr, bus.src_a, bus.src_b};
  assign bus.busy      = '0;
  assign bus.hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed bench for regwb_arbiter: reset, contention, stall and scoreboard scenarios.
// Expectations adapt to whether REGWB_SCOREBOARD_EN is defined.
`timescale 1ns/1ps
module tb_regwb_arbiter;

`ifdef REGWB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  regwb_arbiter_if #(.AW(4), .DW(8)) bus ();

  regwb_arbiter #(.AW(4), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester-rule monitor: a pending request must stay valid with a stable payload.
  logic       alu_pend, ld_pend;
  logic [19:0] alu_snap;
  logic [11:0] ld_snap;
  initial begin
    alu_pend = 1'b0;
    ld_pend  = 1'b0;
  end
  always @(negedge clk) begin
    if (!rst && alu_pend) begin
      checks++;
      if ({bus.alu_valid, bus.alu_addr, bus.alu_data, bus.alu_flags} !== {1'b1, alu_snap}) begin
        errors++;
        $display("FAIL alu_hold: got %h required %h",
                 {bus.alu_valid, bus.alu_addr, bus.alu_data, bus.alu_flags}, {1'b1, alu_snap});
      end
    end
    if (!rst && ld_pend) begin
      checks++;
      if ({bus.ld_valid, bus.ld_addr, bus.ld_data} !== {1'b1, ld_snap}) begin
        errors++;
        $display("FAIL ld_hold: got %h required %h",
                 {bus.ld_valid, bus.ld_addr, bus.ld_data}, {1'b1, ld_snap});
      end
    end
    alu_pend = bus.alu_valid && !bus.alu_ready;
    alu_snap = {bus.alu_addr, bus.alu_data, bus.alu_flags};
    ld_pend  = bus.ld_valid && !bus.ld_ready;
    ld_snap  = {bus.ld_addr, bus.ld_data};
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd3; bus.alu_data = 8'h11; bus.alu_flags = 8'hA5;
    bus.ld_valid  = 1'b1; bus.ld_addr  = 4'd5; bus.ld_data  = 8'h22;
    bus.bank_stall = 1'b0;
    bus.iss_valid = 1'b0; bus.iss_addr = '0; bus.src_a = '0; bus.src_b = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({bus.alu_ready, bus.ld_ready} !== 2'b00) begin
        errors++;
        $display("FAIL reset_ready: got %b required 00", {bus.alu_ready, bus.ld_ready});
      end
      checks++;
      if ({bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.sreg_data, bus.busy} !==
          {1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 16'h0000}) begin
        errors++;
        $display("FAIL reset_regs: got %h required 0",
                 {bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.sreg_data, bus.busy});
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.alu_ready, bus.ld_ready} !== 2'b10) begin
      errors++;
      $display("FAIL first_grant: got %b required 10", {bus.alu_ready, bus.ld_ready});
    end
  endtask

  task automatic test_contention();
    tick();
    checks++;
    if ({bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.sreg_data, bus.alu_ready, bus.ld_ready} !==
        {1'b1, 1'b1, 4'd3, 8'h11, 8'hA5, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL cont_1: got %h required %h",
               {bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.sreg_data, bus.alu_ready, bus.ld_ready},
               {1'b1, 1'b1, 4'd3, 8'h11, 8'hA5, 1'b0, 1'b1});
    end
    tick();
    checks++;
    if ({bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.sreg_data, bus.alu_ready, bus.ld_ready} !==
        {1'b1, 1'b0, 4'd5, 8'h22, 8'hA5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL cont_2: got %h required %h",
               {bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.sreg_data, bus.alu_ready, bus.ld_ready},
               {1'b1, 1'b0, 4'd5, 8'h22, 8'hA5, 1'b1, 1'b0});
    end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    checks++;
    if ({bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.alu_ready, bus.ld_ready} !==
        {1'b1, 1'b1, 4'd3, 8'h11, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL cont_3: got %h required %h",
               {bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.alu_ready, bus.ld_ready},
               {1'b1, 1'b1, 4'd3, 8'h11, 1'b0, 1'b1});
    end
    tick();
    bus.ld_valid = 1'b0;
    #1;
    checks++;
    if ({bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.alu_ready, bus.ld_ready} !==
        {1'b1, 1'b0, 4'd5, 8'h22, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL cont_4: got %h required %h",
               {bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.alu_ready, bus.ld_ready},
               {1'b1, 1'b0, 4'd5, 8'h22, 1'b0, 1'b0});
    end
    tick();
    checks++;
    if ({bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.sreg_data} !==
        {1'b0, 1'b0, 4'd5, 8'h22, 8'hA5}) begin
      errors++;
      $display("FAIL cont_idle_hold: got %h required %h",
               {bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.sreg_data},
               {1'b0, 1'b0, 4'd5, 8'h22, 8'hA5});
    end
  endtask

  task automatic test_stall();
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd9; bus.alu_data = 8'h33; bus.alu_flags = 8'h0F;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_alu_ready: got %b required 1", bus.alu_ready);
    end
    tick();
    bus.alu_valid = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_addr = 4'd7; bus.ld_data = 8'h5A;
    bus.bank_stall = 1'b1;
    #1;
    checks++;
    if ({bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.sreg_data} !==
        {1'b1, 1'b1, 4'd9, 8'h33, 8'h0F}) begin
      errors++;
      $display("FAIL stall_write_completes: got %h required %h",
               {bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.sreg_data},
               {1'b1, 1'b1, 4'd9, 8'h33, 8'h0F});
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      checks++;
      if (bus.ld_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ld_ready_%0d: got %b required 0", i, bus.ld_ready);
      end
    end
    checks++;
    if (bus.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_write: got %b required 0", bus.wr_en);
    end
    tick();
    bus.bank_stall = 1'b0;
    #1;
    checks++;
    if (bus.ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %b required 1", bus.ld_ready);
    end
    tick();
    bus.ld_valid = 1'b0;
    #1;
    checks++;
    if ({bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.sreg_data} !==
        {1'b1, 1'b0, 4'd7, 8'h5A, 8'h0F}) begin
      errors++;
      $display("FAIL stall_load_write: got %h required %h",
               {bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.sreg_data},
               {1'b1, 1'b0, 4'd7, 8'h5A, 8'h0F});
    end
    tick();
  endtask

  task automatic test_scoreboard();
    bus.iss_valid = 1'b1; bus.iss_addr = 4'd4; bus.src_a = 4'd0; bus.src_b = 4'd0;
    #1;
    checks++;
    if (bus.hazard !== 1'b0) begin
      errors++;
      $display("FAIL sb_issue_clear: got %b required 0", bus.hazard);
    end
    tick();
    bus.iss_valid = 1'b0; bus.src_a = 4'd4;
    #1;
    checks++;
    if ({bus.busy, bus.hazard} !== {(SB ? 16'h0010 : 16'h0000), SB}) begin
      errors++;
      $display("FAIL sb_src_a: got %h required %h", {bus.busy, bus.hazard}, {(SB ? 16'h0010 : 16'h0000), SB});
    end
    bus.src_a = 4'd0; bus.src_b = 4'd4;
    #1;
    checks++;
    if (bus.hazard !== SB) begin
      errors++;
      $display("FAIL sb_src_b: got %b required %b", bus.hazard, SB);
    end
    bus.src_b = 4'd0; bus.iss_valid = 1'b1; bus.iss_addr = 4'd4;
    #1;
    checks++;
    if (bus.hazard !== SB) begin
      errors++;
      $display("FAIL sb_iss_waw: got %b required %b", bus.hazard, SB);
    end
    bus.iss_addr = 4'd6; bus.src_a = 4'd4;
    tick();
    bus.iss_valid = 1'b0; bus.src_a = 4'd0;
    bus.ld_valid = 1'b1; bus.ld_addr = 4'd4; bus.ld_data = 8'h44;
    #1;
    checks++;
    if ({bus.busy, bus.ld_ready} !== {(SB ? 16'h0010 : 16'h0000), 1'b1}) begin
      errors++;
      $display("FAIL sb_stalled_issue_ignored: got %h required %h",
               {bus.busy, bus.ld_ready}, {(SB ? 16'h0010 : 16'h0000), 1'b1});
    end
    tick();
    bus.ld_valid = 1'b0; bus.src_a = 4'd4;
    #1;
    checks++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.hazard} !==
        {1'b1, 4'd4, 8'h44, (SB ? 16'h0010 : 16'h0000), SB}) begin
      errors++;
      $display("FAIL sb_write_cycle: got %h required %h",
               {bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.hazard},
               {1'b1, 4'd4, 8'h44, (SB ? 16'h0010 : 16'h0000), SB});
    end
    tick();
    checks++;
    if ({bus.wr_en, bus.busy, bus.hazard} !== {1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL sb_cleared: got %h required 0", {bus.wr_en, bus.busy, bus.hazard});
    end
    bus.src_a = 4'd0;
  endtask

  task automatic test_set_clear();
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd2; bus.alu_data = 8'h77; bus.alu_flags = 8'h3C;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL sc_alu_ready: got %b required 1", bus.alu_ready);
    end
    tick();
    bus.alu_valid = 1'b0; bus.iss_valid = 1'b1; bus.iss_addr = 4'd2;
    #1;
    checks++;
    if ({bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.sreg_data, bus.hazard} !==
        {1'b1, 1'b1, 4'd2, 8'h77, 8'h3C, 1'b0}) begin
      errors++;
      $display("FAIL sc_write_cycle: got %h required %h",
               {bus.wr_en, bus.sreg_we, bus.wr_addr, bus.wr_data, bus.sreg_data, bus.hazard},
               {1'b1, 1'b1, 4'd2, 8'h77, 8'h3C, 1'b0});
    end
    tick();
    bus.iss_valid = 1'b0; bus.src_b = 4'd2;
    #1;
    checks++;
    if ({bus.wr_en, bus.busy, bus.hazard} !== {1'b0, (SB ? 16'h0004 : 16'h0000), SB}) begin
      errors++;
      $display("FAIL sc_set_wins: got %h required %h",
               {bus.wr_en, bus.busy, bus.hazard}, {1'b0, (SB ? 16'h0004 : 16'h0000), SB});
    end
    tick();
    checks++;
    if (bus.busy !== (SB ? 16'h0004 : 16'h0000)) begin
      errors++;
      $display("FAIL sc_busy_holds: got %h required %h", bus.busy, (SB ? 16'h0004 : 16'h0000));
    end
    bus.src_b = 4'd0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_contention();
    test_stall();
    test_scoreboard();
    test_set_clear();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
